// File: rtl/lfsr_seq_arb.sv
// lfsr_seq_arb: two-requester round-robin front end for a shared external LFSR.
// A grant latches the owner's seed and step count. The LFSR is then loaded
// for one cycle and shifted 'steps' times. The final word is returned with
// a one-cycle ack that also carries wrap (the register got back to the seed)
// and err (all-zero seed rejected).
module lfsr_seq_arb #(
   parameter int NBITS = 16,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req0,
   input  logic [NBITS-1:0] seed0,
   input  logic [CNT_W-1:0] steps0,
   input  logic             req1,
   input  logic [NBITS-1:0] seed1,
   input  logic [CNT_W-1:0] steps1,
   output logic             ack0,
   output logic             ack1,
   output logic [NBITS-1:0] result,
   output logic             wrap,
   output logic             err,
   output logic             busy,
   output logic [1:0]       gnt,
   output logic             lfsr_we,
   output logic [NBITS-1:0] lfsr_data,
   input  logic [NBITS-1:0] lfsr_q,
   input  logic             lfsr_fin
);

   typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt;        // RUN cycles still to go
   logic             rr;         // side preferred when both request (0 = req0)
   logic             first_run;  // first RUN cycle: LFSR still holds the bare seed
   logic             ran;        // at least one shift was issued
   logic             wrap_seen;  // seed reappeared during an earlier RUN cycle

   logic             pick;       // side that wins if a grant happens now
   logic [NBITS-1:0] pick_seed;
   logic [CNT_W-1:0] pick_steps;

   // Arbitration: a lone requester always wins; on contention the rr pointer decides
   always_comb begin
      pick = 1'b0;
      if (req0 && req1) begin
         pick = rr;
      end else if (req1) begin
         pick = 1'b1;
      end
   end

   assign pick_seed  = pick ? seed1  : seed0;
   assign pick_steps = pick ? steps1 : steps0;

   // Control FSM with registered handshake and LFSR-control outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         rr        <= 1'b0;
         first_run <= 1'b0;
         ran       <= 1'b0;
         wrap_seen <= 1'b0;
         ack0      <= 1'b0;
         ack1      <= 1'b0;
         err       <= 1'b0;
         busy      <= 1'b0;
         gnt       <= 2'b00;
         lfsr_we   <= 1'b0;
         lfsr_data <= '0;
      end else begin
         ack0    <= 1'b0;
         ack1    <= 1'b0;
         lfsr_we <= 1'b0;
         case (state)
            IDLE: begin
               if (req0 || req1) begin
                  gnt       <= pick ? 2'b10 : 2'b01;
                  rr        <= ~pick;
                  lfsr_data <= pick_seed;
                  cnt       <= pick_steps;
                  wrap_seen <= 1'b0;
                  ran       <= 1'b0;
                  busy      <= 1'b1;
                  if (pick_seed == '0) begin
                     // All-zero seed would lock the LFSR: answer at once, never load it
                     err   <= 1'b1;
                     ack0  <= ~pick;
                     ack1  <= pick;
                     state <= DONE;
                  end else begin
                     err     <= 1'b0;
                     lfsr_we <= 1'b1;
                     state   <= LOAD;
                  end
               end
            end
            LOAD: begin
               first_run <= 1'b1;
               if (cnt == '0) begin
                  ack0  <= gnt[0];
                  ack1  <= gnt[1];
                  state <= DONE;
               end else begin
                  ran   <= 1'b1;
                  state <= RUN;
               end
            end
            RUN: begin
               first_run <= 1'b0;
               if (!first_run && lfsr_fin) begin
                  wrap_seen <= 1'b1;
               end
               cnt <= cnt - CNT_W'(1);
               if (cnt == CNT_W'(1)) begin
                  ack0  <= gnt[0];
                  ack1  <= gnt[1];
                  state <= DONE;
               end
            end
            DONE: begin
               state <= IDLE;
               busy  <= 1'b0;
               gnt   <= 2'b00;
               err   <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // The last shift lands on the DONE cycle, so the register is read live there;
   // the return to the seed after the final shift is also caught live on lfsr_fin.
   assign result = (state == DONE && !err) ? lfsr_q : '0;
   assign wrap   = (state == DONE) && (wrap_seen || (ran && lfsr_fin));

endmodule

// File: tb/tb_lfsr_seq_arb.sv
// tb_lfsr_seq_arb: directed bench for lfsr_seq_arb with a behavioural LFSR on
// the shared-LFSR side. The LFSR is a 12-bit Fibonacci register shifting left
// with feedback d[12]^d[3]^d[1] (1-indexed), so seed 0x001 steps to 0x003.
`timescale 1ns/1ps
module tb_lfsr_seq_arb;
   localparam int NB = 12;
   localparam int CW = 16;

   logic          clk = 1'b0;
   logic          rst;
   logic          req0, req1;
   logic [NB-1:0] seed0, seed1;
   logic [CW-1:0] steps0, steps1;
   logic          ack0, ack1, wrap, err, busy, lfsr_we, lfsr_fin;
   logic [NB-1:0] result, lfsr_data;
   logic [1:0]    gnt;
   logic [NB-1:0] lq = '0;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   lfsr_seq_arb #(.NBITS(NB), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst),
      .req0(req0), .seed0(seed0), .steps0(steps0),
      .req1(req1), .seed1(seed1), .steps1(steps1),
      .ack0(ack0), .ack1(ack1), .result(result), .wrap(wrap), .err(err),
      .busy(busy), .gnt(gnt), .lfsr_we(lfsr_we), .lfsr_data(lfsr_data),
      .lfsr_q(lq), .lfsr_fin(lfsr_fin)
   );

   function automatic logic [NB-1:0] lfsr_next(input logic [NB-1:0] x);
      return {x[10:0], x[11] ^ x[2] ^ x[0]};
   endfunction

   // External LFSR: load when we, otherwise shift every edge
   always @(posedge clk) begin
      if (lfsr_we) lq <= lfsr_data;
      else         lq <= lfsr_next(lq);
   end
   assign lfsr_fin = (lq == lfsr_data);

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   task automatic sync();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst  = 1'b1;
      req0 = 1'b0;
      req1 = 1'b0;
      sync();
      sync();
      rst = 1'b0;
   endtask

   // Issue one request at the start of an IDLE cycle (called #1 after posedge).
   // lat counts cycles from the cycle the request is first sampled; -1 on timeout.
   task automatic do_req(input int side, input logic [NB-1:0] seed, input logic [CW-1:0] steps,
                         output logic [NB-1:0] res, output logic w, output logic e,
                         output int lat, output int we_cnt, output int other_ack);
      if (side == 0) begin seed0 = seed; steps0 = steps; req0 = 1'b1; end
      else           begin seed1 = seed; steps1 = steps; req1 = 1'b1; end
      lat = -1; we_cnt = 0; other_ack = 0; res = '0; w = 1'b0; e = 1'b0;
      for (int k = 0; k < int'(steps) + 10; k++) begin
         @(negedge clk);
         if (lfsr_we) we_cnt++;
         if ((side == 0) ? ack1 : ack0) other_ack++;
         if ((side == 0) ? ack0 : ack1) begin
            lat = k; res = result; w = wrap; e = err;
            break;
         end
      end
      sync();
      req0 = 1'b0;
      req1 = 1'b0;
      $display("txn side=%0d seed=0x%03h steps=%0d lat=%0d result=0x%03h wrap=%0b err=%0b we=%0d",
               side, seed, steps, lat, res, w, e, we_cnt);
      sync();
   endtask

   logic [NB-1:0] r;
   logic          w, e;
   int            lat, wec, oth;
   logic [NB-1:0] x;
   int            period;
   int            n, viol, acks;
   logic          a0, a1;
   logic [1:0]    exp_gnt;

   initial begin
      rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
      seed0 = '0; seed1 = '0; steps0 = '0; steps1 = '0;

      // Reset state
      do_reset();
      @(negedge clk);
      check("rst_busy", busy, 0);
      check("rst_gnt", gnt, 0);
      check("rst_ack0", ack0, 0);
      check("rst_ack1", ack1, 0);
      check("rst_wrap", wrap, 0);
      check("rst_err", err, 0);
      check("rst_result", result, 0);
      check("rst_we", lfsr_we, 0);
      check("rst_data", lfsr_data, 0);
      sync();

      // 1: steps=0 returns the seed two cycles later
      do_req(0, 12'h001, 16'd0, r, w, e, lat, wec, oth);
      check("t1_lat", lat, 2);
      check("t1_result", r, 12'h001);
      check("t1_wrap", w, 0);
      check("t1_err", e, 0);
      check("t1_we_cycles", wec, 1);
      check("t1_other_ack", oth, 0);

      // 2: one shift, then a long run against the bench LFSR model
      do_req(0, 12'h001, 16'd1, r, w, e, lat, wec, oth);
      check("t2_lat", lat, 3);
      check("t2_result", r, 12'h003);
      x = 12'h001;
      for (int i = 0; i < 100; i++) x = lfsr_next(x);
      do_req(0, 12'h001, 16'd100, r, w, e, lat, wec, oth);
      check("t2_lat100", lat, 102);
      check("t2_result100", r, x);
      check("t2_err100", e, 0);

      // 3: both requesters contend and re-request; grants must alternate 0,1,0,1
      do_reset();
      seed0 = 12'h0a5; steps0 = 16'd3;
      seed1 = 12'h35c; steps1 = 16'd3;
      req0 = 1'b1; req1 = 1'b1;
      n = 0; viol = 0;
      for (int cyc = 0; cyc < 200 && n < 4; cyc++) begin
         @(negedge clk);
         a0 = ack0; a1 = ack1;
         if (busy && !$onehot(gnt)) viol++;
         if (!busy && gnt != 2'b00) viol++;
         if (a0 || a1) begin
            exp_gnt = (n % 2 == 0) ? 2'b01 : 2'b10;
            check("t3_ack", {30'd0, a1, a0}, {30'd0, exp_gnt});
            check("t3_gnt", {30'd0, gnt}, {30'd0, exp_gnt});
            $display("txn arb n=%0d ack0=%0b ack1=%0b gnt=%b result=0x%03h", n, a0, a1, gnt, result);
            n++;
         end
         sync();
         req0 = !a0;
         req1 = !a1;
      end
      req0 = 1'b0; req1 = 1'b0;
      check("t3_count", n, 4);
      check("t3_gnt_onehot_viol", viol, 0);
      sync();
      sync();

      // 4: zero seed is rejected without touching the LFSR
      do_req(1, 12'h000, 16'd5, r, w, e, lat, wec, oth);
      check("t4_lat", lat, 1);
      check("t4_err", e, 1);
      check("t4_result", r, 0);
      check("t4_we_cycles", wec, 0);
      check("t4_wrap", w, 0);
      check("t4_other_ack", oth, 0);

      // 5: wrap when steps equals the period of seed 0x001, not at period-1
      x = lfsr_next(12'h001);
      period = 1;
      while (x != 12'h001 && period < 5000) begin
         x = lfsr_next(x);
         period++;
      end
      do_req(0, 12'h001, 16'(period), r, w, e, lat, wec, oth);
      check("t5_wrap_period", w, 1);
      check("t5_result_period", r, 12'h001);
      check("t5_lat_period", lat, period + 2);
      do_req(0, 12'h001, 16'(period - 1), r, w, e, lat, wec, oth);
      check("t5_wrap_period_m1", w, 0);

      // 6: reset in the middle of a run abandons it
      seed0 = 12'h001; steps0 = 16'd50; req0 = 1'b1;
      for (int i = 0; i < 10; i++) sync();
      check("t6_busy_before", busy, 1);
      rst = 1'b1; req0 = 1'b0;
      sync();
      rst = 1'b0;
      @(negedge clk);
      check("t6_busy", busy, 0);
      check("t6_gnt", gnt, 0);
      check("t6_ack", {30'd0, ack1, ack0}, 0);
      acks = 0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (ack0 || ack1) acks++;
      end
      check("t6_no_ack", acks, 0);
      sync();
      do_req(1, 12'h123, 16'd2, r, w, e, lat, wec, oth);
      check("t6_req1_lat", lat, 4);
      check("t6_req1_other", oth, 0);

      // rr pointer back at req0 after reset: simultaneous requests go to req0
      do_reset();
      seed0 = 12'h005; steps0 = 16'd1;
      seed1 = 12'h007; steps1 = 16'd1;
      req0 = 1'b1; req1 = 1'b1;
      a0 = 1'b0; a1 = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (ack0 || ack1) begin
            a0 = ack0; a1 = ack1;
            break;
         end
      end
      check("t6_rr_first", {30'd0, a1, a0}, 32'd1);
      $display("txn rr first ack0=%0b ack1=%0b", a0, a1);
      sync();
      req0 = 1'b0; req1 = 1'b0;
      sync();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/lfsr_seq_arb.md
Name: lfsr_seq_arb

Overview:
Controller and arbiter that shares one external `lfsr` instance between two requesters. For each request it seeds the LFSR, steps it a requested number of cycles, and returns the resulting word. It also flags period wrap-around and rejects the all-zero (lock-up) seed. It sits between the replay-buffer address/pattern generators and the LFSR datapath.

Parameters:
NBITS, 16, LFSR register width; also the width of seeds and results.
CNT_W, 16, width of the step-count field.

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
req0  input  1  requester 0 request; held high until ack0
seed0  input  NBITS  requester 0 seed; stable while req0 is high
steps0  input  CNT_W  requester 0 shift count; stable while req0 is high
req1  input  1  requester 1 request
seed1  input  NBITS  requester 1 seed
steps1  input  CNT_W  requester 1 shift count
ack0  output  1  one-cycle completion pulse to requester 0
ack1  output  1  one-cycle completion pulse to requester 1
result  output  NBITS  LFSR word; valid while ack0 or ack1 is high
wrap  output  1  LFSR returned to its seed during the run; valid with ack
err  output  1  request rejected (seed==0); valid with ack
busy  output  1  high in every non-IDLE state
gnt  output  2  one-hot current owner; 0 in IDLE
lfsr_we  output  1  to LFSR `we`: load lfsr_data this edge, else shift
lfsr_data  output  NBITS  to LFSR `data`: latched seed
lfsr_q  input  NBITS  LFSR register contents
lfsr_fin  input  1  LFSR register equals lfsr_data

Behaviour:
- Clock and reset: one clock domain; reset is synchronous and active-high, on ports clk / rst.
- Reset values: state=IDLE; ack0=ack1=0; wrap=0; err=0; result=0; busy=0; gnt=0; lfsr_we=0; lfsr_data=0; rr pointer=req0.
- Reset mid-operation abandons the run. No ack is issued, and the LFSR contents are don't-care.
- FSM states: IDLE, LOAD, RUN, DONE.
- IDLE:
  - If any req is high, pick an owner, latch seed/steps/owner, and clear wrap.
  - Round-robin: if both requests are high, grant the side the rr pointer names. After each grant the pointer moves to the other side.
  - If only one request is high, grant it regardless of the pointer.
  - If the latched seed==0, go to DONE with err=1 and skip the LFSR.
  - Otherwise go to LOAD.
- LOAD (1 cycle): lfsr_we=1 and lfsr_data=seed, so the LFSR loads the seed at the end of this cycle. Load a cycle counter with steps. Next state is RUN, or DONE if steps==0.
- RUN:
  - lfsr_we=0 and lfsr_data holds the seed; the LFSR shifts every edge.
  - The counter decrements each cycle; leave for DONE after exactly `steps` RUN cycles.
  - If lfsr_fin is sampled high in any RUN cycle after the first, set wrap. This means the state has returned to the seed, i.e. the period divides the elapsed shifts.
- DONE (1 cycle):
  - result=lfsr_q, or 0 when err=1.
  - Pulse ack for the owner and drive wrap/err.
  - Next state is IDLE. gnt clears on entry to IDLE.
- Latency: with req sampled in IDLE at cycle c, ack is at cycle c+2+steps. With err=1, ack is at c+1.
- Requester rules:
  - A requester drops req in the cycle after ack.
  - If req is still high in the next IDLE cycle, it is a new request.
  - A non-owner's req is ignored until IDLE.
- lfsr_we is high only in LOAD. No simultaneous load and shift is ever issued.
- steps=2^CNT_W-1 is legal; the counter must not wrap.

Test Plan:
1. Reset, then req0 with seed0=0x0001, steps0=0 -> ack0 at c+2; result=0x0001; wrap=0; err=0; lfsr_we high exactly one cycle.
2. req0 with seed0=0x0001, steps0=1 -> ack0 at c+3; result=0x0003 (feedback d[12]^d[3]^d[1], 1-indexed = 1). Bench LFSR model matches for steps0=100.
3. req0 and req1 raised in the same cycle, each re-requesting after ack, for 4 requests -> grants alternate 0,1,0,1; gnt one-hot while busy; ack only to the owner.
4. req1 with seed1=0x0000 -> ack1 at c+1 with err=1, result=0; lfsr_we never asserted.
5. Run with steps equal to the bench-computed period of seed 0x0001 -> wrap=1 with ack. Same seed with period-1 steps -> wrap=0.
6. rst asserted mid-RUN (steps=50) -> next cycle: IDLE, busy=0, gnt=0, no ack. A following req1 is served first only if req0 is low; with both high, req0 wins (rr reset).
